// File: rtl/lsu_pkg.sv
// Shared encodings for the MIPS load/store unit: op codes, FSM states, byte-lane offsets
// and the access-legality check applied at request acceptance.
package lsu_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } lsu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    // Big-endian lanes: offset 0 is the most significant byte of the word.
    localparam logic [1:0] LANE_B0 = 2'd0;
    localparam logic [1:0] LANE_B1 = 2'd1;
    localparam logic [1:0] LANE_B2 = 2'd2;
    localparam logic [1:0] LANE_B3 = 2'd3;

    function automatic logic is_load(lsu_op_e op);
        return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
               (op == OP_LB) || (op == OP_LBU);
    endfunction

    function automatic logic access_err(lsu_op_e op, logic [1:0] lo, logic out_of_range);
        logic misaligned;
        case (op)
            OP_LW, OP_SW:         misaligned = (lo != 2'b00);
            OP_LH, OP_LHU, OP_SH: misaligned = lo[0];
            default:              misaligned = 1'b0;
        endcase
        return misaligned || out_of_range;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: extracts and extends a sub-word load result, and
// merges store data into a previously read word for read-modify-write stores.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [2:0]  op,
    input  logic [1:0]  offset,
    output logic [31:0] rdata,
    output logic [31:0] merged
);

    lsu_op_e     op_e;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign op_e = lsu_op_e'(op);

    always_comb begin
        case (offset)
            LANE_B0: byte_sel = word[31:24];
            LANE_B1: byte_sel = word[23:16];
            LANE_B2: byte_sel = word[15:8];
            default: byte_sel = word[7:0];
        endcase
        half_sel = offset[1] ? word[15:0] : word[31:16];
    end

    always_comb begin
        rdata = 32'd0;
        case (op_e)
            OP_LW:   rdata = word;
            OP_LH:   rdata = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  rdata = {16'd0, half_sel};
            OP_LB:   rdata = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  rdata = {24'd0, byte_sel};
            default: rdata = 32'd0;
        endcase
    end

    always_comb begin
        merged = word;
        case (op_e)
            OP_SW: merged = wdata;
            OP_SH: begin
                if (offset[1]) merged = {word[31:16], wdata[15:0]};
                else           merged = {wdata[15:0], word[15:0]};
            end
            OP_SB: begin
                case (offset)
                    LANE_B0: merged = {wdata[7:0], word[23:0]};
                    LANE_B1: merged = {word[31:24], wdata[7:0], word[15:0]};
                    LANE_B2: merged = {word[31:16], wdata[7:0], word[7:0]};
                    default: merged = {word[31:8], wdata[7:0]};
                endcase
            end
            default: merged = word;
        endcase
    end

endmodule

// File: rtl/mips_lsu_master.sv
// MIPS load/store unit mastering a word-only data memory; event counters under LSU_STATS_EN.
// Latency load/SW 2, SH/SB 3 (read-modify-write), error 1; one request in flight, resp has no backpressure.
module mips_lsu_master
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 128,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_readAddress,
    output logic              mem_MemRead,
    input  logic [31:0]       mem_readData,
    output logic [ADDR_W-1:0] mem_writeAddress,
    output logic [31:0]       mem_writeData,
    output logic              mem_MemWrite,
    output logic [15:0]       stat_loads,
    output logic [15:0]       stat_stores,
    output logic [15:0]       stat_errs
);

    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(4 * MEM_WORDS);

    lsu_state_e        state_q, state_d;
    lsu_op_e           op_q, req_op_e;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [ADDR_W-1:0] rd_addr_q, wr_addr_q;
    logic [31:0]       wr_data_q, rdata_q;
    logic              err_q;

    logic              accept, req_err, out_of_range;
    logic [ADDR_W-1:0] req_word_addr, cur_word_addr;
    logic [31:0]       lane_rdata, lane_merged;

    assign req_op_e      = lsu_op_e'(req_op);
    assign accept        = req_valid && (state_q == ST_IDLE);
    // Widened compare so an address near the top of the space cannot wrap past the limit.
    assign out_of_range  = ({1'b0, req_addr} >= ADDR_LIMIT);
    assign req_err       = access_err(req_op_e, req_addr[1:0], out_of_range);
    assign req_word_addr = {req_addr[ADDR_W-1:2], 2'b00};
    assign cur_word_addr = {addr_q[ADDR_W-1:2], 2'b00};

    lsu_lane_align u_align (
        .word   (mem_readData),
        .wdata  (wdata_q),
        .op     (op_q),
        .offset (addr_q[1:0]),
        .rdata  (lane_rdata),
        .merged (lane_merged)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (req_err)               state_d = ST_RESP;
                    else if (req_op_e == OP_SW) state_d = ST_WR;
                    else                        state_d = ST_RD;
                end
            end
            ST_RD:   state_d = is_load(op_q) ? ST_RESP : ST_WR;
            ST_WR:   state_d = ST_RESP;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Enables decode straight from state so an async reset in WR drops the write at once.
    assign req_ready     = (state_q == ST_IDLE);
    assign mem_MemRead   = (state_q == ST_RD);
    assign mem_MemWrite  = (state_q == ST_WR);
    assign resp_valid    = (state_q == ST_RESP);
    assign resp_rdata    = rdata_q;
    assign resp_err      = err_q;
    assign mem_readAddress  = rd_addr_q;
    assign mem_writeAddress = wr_addr_q;
    assign mem_writeData    = wr_data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q      <= OP_LW;
            addr_q    <= '0;
            wdata_q   <= 32'd0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= 32'd0;
            rdata_q   <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_q    <= req_op_e;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        rdata_q <= 32'd0;
                        err_q   <= req_err;
                        if (!req_err) begin
                            if (req_op_e == OP_SW) begin
                                wr_addr_q <= req_word_addr;
                                wr_data_q <= req_wdata;
                            end else begin
                                rd_addr_q <= req_word_addr;
                            end
                        end
                    end
                end
                ST_RD: begin
                    if (is_load(op_q)) begin
                        rdata_q <= lane_rdata;
                    end else begin
                        wr_addr_q <= cur_word_addr;
                        wr_data_q <= lane_merged;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef LSU_STATS_EN
    logic [15:0] loads_q, stores_q, errs_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            loads_q  <= 16'd0;
            stores_q <= 16'd0;
            errs_q   <= 16'd0;
        end else if (state_q == ST_RESP) begin
            if (err_q) begin
                if (errs_q != 16'hFFFF) errs_q <= errs_q + 16'd1;
            end else if (is_load(op_q)) begin
                if (loads_q != 16'hFFFF) loads_q <= loads_q + 16'd1;
            end else begin
                if (stores_q != 16'hFFFF) stores_q <= stores_q + 16'd1;
            end
        end
    end

    assign stat_loads  = loads_q;
    assign stat_stores = stores_q;
    assign stat_errs   = errs_q;
`else
    assign stat_loads  = 16'd0;
    assign stat_stores = 16'd0;
    assign stat_errs   = 16'd0;
`endif

endmodule

// File: tb/tb_mips_lsu_master.sv
// Directed bench for mips_lsu_master against a 128-word combinational-read memory.
module tb_mips_lsu_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_readAddress, mem_writeAddress, mem_writeData, mem_readData;
    logic        mem_MemRead, mem_MemWrite;
    logic [15:0] stat_loads, stat_stores, stat_errs;

    always #5 clk = ~clk;

    mips_lsu_master #(.MEM_WORDS(128), .ADDR_W(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_op           (req_op),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_rdata       (resp_rdata),
        .resp_err         (resp_err),
        .mem_readAddress  (mem_readAddress),
        .mem_MemRead      (mem_MemRead),
        .mem_readData     (mem_readData),
        .mem_writeAddress (mem_writeAddress),
        .mem_writeData    (mem_writeData),
        .mem_MemWrite     (mem_MemWrite),
        .stat_loads       (stat_loads),
        .stat_stores      (stat_stores),
        .stat_errs        (stat_errs)
    );

    // Data memory: combinational read, write on the edge ending a MemWrite cycle.
    logic [31:0] mem [0:127];
    logic        load_en = 1'b0;
    logic [6:0]  load_idx = 7'd0;
    logic [31:0] load_val = 32'd0;

    always @(posedge clk) begin
        if (load_en)           mem[load_idx] <= load_val;
        else if (mem_MemWrite) mem[mem_writeAddress[8:2]] <= mem_writeData;
    end
    assign mem_readData = mem[mem_readAddress[8:2]];

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] r_rdata, r_wdat, r_waddr, r_raddr;
    logic        r_err, r_done;
    int          r_lat, r_rd, r_wr, r_both;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic poke(input int idx, input logic [31:0] val);
        @(negedge clk);
        load_en  = 1'b1;
        load_idx = 7'(idx);
        load_val = val;
        @(posedge clk);
        #1 load_en = 1'b0;
    endtask

    task automatic xact(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd);
        int n;
        r_rd = 0; r_wr = 0; r_both = 0; r_lat = 0; r_done = 1'b0;
        r_rdata = 32'hxxxx_xxxx; r_err = 1'bx; r_wdat = 32'd0; r_waddr = 32'd0; r_raddr = 32'd0;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        req_op = op; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        r_lat = 1;
        for (int i = 0; i < 10 && !r_done; i++) begin
            @(negedge clk);
            if (mem_MemRead && mem_MemWrite) r_both++;
            if (mem_MemRead) begin r_rd++; r_raddr = mem_readAddress; end
            if (mem_MemWrite) begin r_wr++; r_wdat = mem_writeData; r_waddr = mem_writeAddress; end
            if (resp_valid) begin
                r_done  = 1'b1;
                r_rdata = resp_rdata;
                r_err   = resp_err;
            end else begin
                @(posedge clk);
                r_lat++;
            end
        end
        check("resp_seen", r_done, 1);
        check("no_rd_wr_overlap", r_both, 0);
    endtask

    task automatic load_case(input string tag, input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] exp);
        xact(op, a, 32'd0);
        check({tag, "_rdata"}, r_rdata, exp);
        check({tag, "_err"}, r_err, 0);
        check({tag, "_lat"}, r_lat, 2);
        check({tag, "_reads"}, r_rd, 1);
        check({tag, "_writes"}, r_wr, 0);
    endtask

    task automatic err_case(input string tag, input logic [2:0] op, input logic [31:0] a);
        xact(op, a, 32'h1234_5678);
        check({tag, "_err"}, r_err, 1);
        check({tag, "_rdata"}, r_rdata, 0);
        check({tag, "_lat"}, r_lat, 1);
        check({tag, "_reads"}, r_rd, 0);
        check({tag, "_writes"}, r_wr, 0);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            case (i)
                8:       poke(i, 32'h1122_3344);
                12:      poke(i, 32'h80FF_7F01);
                16:      poke(i, 32'h1234_5678);
                127:     poke(i, 32'hCAFE_F00D);
                default: poke(i, 32'h0000_0000);
            endcase
        end

        // Reset state
        #1;
        check("rst_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_rdata", resp_rdata, 0);
        check("rst_err", resp_err, 0);
        check("rst_memread", mem_MemRead, 0);
        check("rst_memwrite", mem_MemWrite, 0);
        check("rst_raddr", mem_readAddress, 0);
        check("rst_waddr", mem_writeAddress, 0);
        check("rst_wdata", mem_writeData, 0);
        check("rst_stats", {stat_loads, stat_stores}, 0);
        check("rst_stat_errs", stat_errs, 0);
        @(negedge clk);
        reset = 1'b0;

        // SW then LW of the same word
        xact(3'd5, 32'h10, 32'hDEAD_BEEF);
        check("sw_writes", r_wr, 1);
        check("sw_reads", r_rd, 0);
        check("sw_wdata", r_wdat, 32'hDEAD_BEEF);
        check("sw_waddr", r_waddr, 32'h10);
        check("sw_lat", r_lat, 2);
        check("sw_err", r_err, 0);
        check("sw_rdata", r_rdata, 0);
        check("sw_mem", mem[4], 32'hDEAD_BEEF);
        load_case("lw10", 3'd0, 32'h10, 32'hDEAD_BEEF);
        check("lw10_raddr", r_raddr, 32'h10);

        // SB read-modify-write
        xact(3'd7, 32'h22, 32'h0000_00AA);
        check("sb_reads", r_rd, 1);
        check("sb_writes", r_wr, 1);
        check("sb_raddr", r_raddr, 32'h20);
        check("sb_waddr", r_waddr, 32'h20);
        check("sb_wdata", r_wdat, 32'h1122_AA44);
        check("sb_lat", r_lat, 3);
        check("sb_err", r_err, 0);
        check("sb_mem", mem[8], 32'h1122_AA44);

        // Extraction on 0x80FF7F01
        load_case("lb30", 3'd3, 32'h30, 32'hFFFF_FF80);
        load_case("lbu30", 3'd4, 32'h30, 32'h0000_0080);
        load_case("lh32", 3'd1, 32'h32, 32'h0000_7F01);
        load_case("lhu30", 3'd2, 32'h30, 32'h0000_80FF);
        load_case("lh30", 3'd1, 32'h30, 32'hFFFF_80FF);
        load_case("lb33", 3'd3, 32'h33, 32'h0000_0001);
        load_case("lw_top", 3'd0, 32'h1FC, 32'hCAFE_F00D);

        // Error responses
        err_case("lw13", 3'd0, 32'h13);
        err_case("sh21", 3'd6, 32'h21);
        err_case("lb200", 3'd3, 32'h200);
        err_case("lw_wrap", 3'd0, 32'hFFFF_FFFC);
        err_case("sw42", 3'd5, 32'h42);

        // Reset during the WR cycle of SW 0x40
        @(negedge clk);
        req_op = 3'd5; req_addr = 32'h40; req_wdata = 32'h5555_5555; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("rstwr_pre_memwrite", mem_MemWrite, 1);
        #2 reset = 1'b1;
        #1;
        check("rstwr_memwrite", mem_MemWrite, 0);
        check("rstwr_ready", req_ready, 1);
        check("rstwr_resp_valid", resp_valid, 0);
        check("rstwr_waddr", mem_writeAddress, 0);
        check("rstwr_wdata", mem_writeData, 0);
        check("rstwr_raddr", mem_readAddress, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        check("rstwr_mem", mem[16], 32'h1234_5678);

        // 3 loads, 2 stores, 1 error since the reset
        load_case("post_lw10", 3'd0, 32'h10, 32'hDEAD_BEEF);
        load_case("post_lb30", 3'd3, 32'h30, 32'hFFFF_FF80);
        xact(3'd5, 32'h44, 32'h0000_0001);
        check("sw44_mem", mem[17], 32'h0000_0001);
        xact(3'd6, 32'h44, 32'h0000_ABCD);
        check("sh44_wdata", r_wdat, 32'hABCD_0001);
        check("sh44_lat", r_lat, 3);
        check("sh44_mem", mem[17], 32'hABCD_0001);
        load_case("post_lhu30", 3'd2, 32'h30, 32'h0000_80FF);
        err_case("post_lw13", 3'd0, 32'h13);
        @(negedge clk);
`ifdef LSU_STATS_EN
        check("stat_loads", stat_loads, 3);
        check("stat_stores", stat_stores, 2);
        check("stat_errs", stat_errs, 1);
`else
        check("stat_loads", stat_loads, 0);
        check("stat_stores", stat_stores, 0);
        check("stat_errs", stat_errs, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
